fir_coeff_loader: RTL and testbench

Runtime coefficient manager for `fir`. It accepts a stream of signed coefficients over a valid/ready configuration port into a shadow bank. It then commits the bank atomically to the active coefficient bus driving the filter, only in a cycle where the filter is not accepting a sample. It lets the RRC and other filter instances be retuned in-system without corrupting an in-flight output.

---
 rtl/fir_coeff_loader.sv | 116 +++++++++++
 tb/tb_fir_coeff_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Runtime coefficient manager for the fir block.
// Signed coefficients arrive one per accepted beat on a valid/ready port and
// collect in a shadow bank. A complete load is copied atomically into the
// active bank, but only on an edge where the filter is not taking a sample.
// Loads of the wrong length are rejected and leave the active bank untouched.
module fir_coeff_loader #(
  parameter int NumTaps               = 21,
  parameter int CoefficientLengthBits = 14,
  parameter logic [NumTaps*CoefficientLengthBits-1:0] ResetCoefficients = '0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [CoefficientLengthBits-1:0]         cfg_data,
  input  logic                                     cfg_valid,
  input  logic                                     cfg_last,
  output logic                                     cfg_ready,
  output logic                                     cfg_error,
  input  logic                                     sample_strobe,
  output logic [NumTaps*CoefficientLengthBits-1:0] coefficients,
  output logic                                     coeff_update,
  output logic                                     busy
);

  localparam int W    = CoefficientLengthBits;
  localparam int IdxW = $clog2(NumTaps);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumTaps - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] PENDING = 2'd3;

  logic [1:0]                state_q;
  logic [IdxW-1:0]           idx_q;
  logic [W-1:0]              shadow [NumTaps];
  logic [NumTaps*W-1:0]      shadow_flat;
  logic                      accept;

  // Handshake and status come straight from registered state, so cfg_ready
  // never depends on cfg_valid.
  assign cfg_ready = (state_q != PENDING);
  assign busy      = (state_q != IDLE);
  assign accept    = cfg_valid && cfg_ready;

  // Capture beats into the shadow bank; DRAIN beats are discarded.
  // NOTE: the shadow bank is reset element by element because it must read as
  // zero after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumTaps; i++) shadow[i] <= '0;
    end else if (accept && (state_q == IDLE || state_q == LOAD)) begin
      shadow[idx_q] <= cfg_data;
    end
  end

  // Flatten the shadow bank with tap 0 in the most significant slot.
  // NOTE: the vector gets a full default before the loop so no bit is left
  // unassigned on any path, which would otherwise infer a latch.
  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NumTaps; i++) begin
      shadow_flat[(NumTaps-i)*W-1 -: W] = shadow[i];
    end
  end

  // Load sequencing, length checking and the atomic commit to the active bank.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      coefficients <= ResetCoefficients;
      cfg_error    <= 1'b0;
      coeff_update <= 1'b0;
    end else begin
      cfg_error    <= 1'b0;
      coeff_update <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= cfg_last ? PENDING : DRAIN;
            end else if (cfg_last) begin
              // Short load: the partial shadow contents are simply abandoned;
              // a later full load overwrites every tap.
              idx_q     <= '0;
              cfg_error <= 1'b1;
              state_q   <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        DRAIN: begin
          if (accept && cfg_last) begin
            cfg_error <= 1'b1;
            state_q   <= IDLE;
          end
        end
        PENDING: begin
          // Commit only when the filter is not consuming a sample this edge.
          if (!sample_strobe) begin
            coefficients <= shadow_flat;
            coeff_update <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: randomized loads against a list-level model of
// load outcomes, with a scoreboard monitor checking every commit/error pulse
// and the stability of the active bank between them.
module tb_fir_coeff_loader;

  localparam int NT = 21;
  localparam int W  = 14;
  localparam int NW = NT * W;
  localparam logic [NW-1:0] RST_BANK = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_last = 1'b0;
  logic          cfg_ready;
  logic          cfg_error;
  logic          sample_strobe = 1'b0;
  logic [NW-1:0] coefficients;
  logic          coeff_update;
  logic          busy;

  fir_coeff_loader #(
    .NumTaps(NT),
    .CoefficientLengthBits(W),
    .ResetCoefficients(RST_BANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_last(cfg_last),
    .cfg_ready(cfg_ready),
    .cfg_error(cfg_error),
    .sample_strobe(sample_strobe),
    .coefficients(coefficients),
    .coeff_update(coeff_update),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            commit;
    logic [NW-1:0] bank;
  } exp_t;

  exp_t          sb[$];
  logic [NW-1:0] model_bank = RST_BANK;
  logic [NW-1:0] mon_bank   = RST_BANK;
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a full-length load becomes the active bank, tap 0 in the MSBs.
  function automatic logic [NW-1:0] pack(input logic [W-1:0] b[$]);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < NT; i++) r[(NT-i)*W-1 -: W] = b[i];
    return r;
  endfunction

  // Monitor: pops an expectation on every pulse, else checks bank stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      mon_bank = RST_BANK;
    end else if (coeff_update || cfg_error) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got update=%0b error=%0b expected none", coeff_update, cfg_error);
      end else begin
        e = sb.pop_front();
        check("pulse_update", NW'(coeff_update), NW'(e.commit));
        check("pulse_error", NW'(cfg_error), NW'(!e.commit));
        check("bank_at_pulse", coefficients, e.bank);
        mon_bank = e.bank;
      end
    end else begin
      check("bank_stable", coefficients, mon_bank);
    end
  end

  // Drives beats one per accepted edge; called and returns at a negedge.
  task automatic drive_beats(input logic [W-1:0] b[$], input int gap_max,
                             input bit with_last, output int acc);
    int waits;
    acc = 0;
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        cfg_valid = 1'b0;
        sample_strobe = 1'($urandom);
        @(negedge clk);
      end
      cfg_valid = 1'b1;
      cfg_data  = b[i];
      cfg_last  = with_last && (i == b.size() - 1);
      sample_strobe = 1'($urandom);
      waits = 0;
      while (!cfg_ready && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      @(negedge clk);
      if (waits < 50) acc++;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Issues one complete load, records its expected outcome and checks timing.
  task automatic issue_load(input logic [W-1:0] b[$], input int gap_max, input int stall);
    exp_t e;
    int   acc, lat, rdy0;
    e.commit = (b.size() == NT);
    e.bank   = e.commit ? pack(b) : model_bank;
    sb.push_back(e);
    drive_beats(b, gap_max, 1'b1, acc);
    check("beats_accepted", NW'(acc), NW'(b.size()));
    if (e.commit) begin
      lat = 0;
      rdy0 = 0;
      while (lat < 200) begin
        sample_strobe = (lat < stall);
        if (!cfg_ready) rdy0++;
        @(negedge clk);
        lat++;
        if (coeff_update) break;
      end
      check("commit_latency", NW'(lat), NW'(stall + 1));
      check("ready_low_cycles", NW'(rdy0), NW'(stall + 1));
      model_bank = e.bank;
    end else begin
      sample_strobe = 1'b0;
      check("error_latency", NW'(cfg_error), NW'(1));
      @(negedge clk);
    end
    sample_strobe = 1'b0;
    check("idle_after_load", NW'(busy), NW'(0));
  endtask

  function automatic void rand_beats(input int len, output logic [W-1:0] b[$]);
    b = {};
    for (int i = 0; i < len; i++) b.push_back(W'($urandom));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nominal[NT] = '{-61, 63, 173, 63, -307, -642, -434, 642, 2371, 3994, 4658,
                        3994, 2371, 642, -434, -642, -307, 63, 173, 63, -61};
    logic [W-1:0]  nom[$];
    logic [W-1:0]  b[$];
    logic [W-1:0]  tap_m61;
    logic [NW-1:0] nom_bank;
    int            acc, len;

    for (int i = 0; i < NT; i++) nom.push_back(W'(nominal[i]));
    nom_bank = pack(nom);
    tap_m61  = W'(-61);

    // Reset state, then 100 quiet cycles.
    repeat (3) @(negedge clk);
    check("rst_bank", coefficients, RST_BANK);
    check("rst_ready", NW'(cfg_ready), NW'(1));
    check("rst_busy", NW'(busy), NW'(0));
    check("rst_error", NW'(cfg_error), NW'(0));
    check("rst_update", NW'(coeff_update), NW'(0));
    #2 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("quiet_ready", NW'(cfg_ready), NW'(1));
    check("quiet_busy", NW'(busy), NW'(0));

    // Nominal load, no gaps or stalls.
    issue_load(nom, 0, 0);
    check("top_tap", NW'(coefficients[NW-1 -: W]), NW'(tap_m61));
    check("bottom_tap", NW'(coefficients[W-1:0]), NW'(tap_m61));

    // Short load so the same bank can be committed again visibly afterwards.
    rand_beats(5, b);
    issue_load(b, 1, 0);
    rand_beats(NT, b);
    issue_load(b, 0, 0);

    // Backpressure gaps and a 3-cycle stall; bus must match the nominal bank.
    issue_load(nom, 3, 3);
    check("stall_bank", coefficients, nom_bank);

    // Long load: drained, rejected, bank untouched.
    rand_beats(25, b);
    issue_load(b, 1, 0);
    check("long_bank", coefficients, nom_bank);

    // Randomized mix of lengths, gaps and stalls.
    for (int k = 0; k < 10; k++) begin
      len = ($urandom_range(2, 0) == 0) ? int'($urandom_range(30, 1)) : NT;
      rand_beats(len, b);
      issue_load(b, int'($urandom_range(3, 0)), int'($urandom_range(4, 0)));
    end

    // Reset after 10 beats of a load.
    issue_load(nom, 0, 0);
    rand_beats(10, b);
    drive_beats(b, 0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("midload_rst_bank", coefficients, RST_BANK);
    check("midload_rst_busy", NW'(busy), NW'(0));
    model_bank = RST_BANK;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midload_idle", NW'(busy), NW'(0));
    rand_beats(NT, b);
    issue_load(b, 0, 0);

    // Reset while PENDING with the filter stalling the commit.
    rand_beats(NT, b);
    drive_beats(b, 0, 1'b1, acc);
    sample_strobe = 1'b1;
    repeat (2) @(negedge clk);
    check("pending_ready", NW'(cfg_ready), NW'(0));
    #2 rst_n = 1'b0;
    #1;
    check("pending_rst_bank", coefficients, RST_BANK);
    model_bank = RST_BANK;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (20) @(negedge clk);
    check("pending_rst_idle", NW'(busy), NW'(0));
    check("pending_rst_bank_after", coefficients, RST_BANK);

    // Every expected pulse must have been observed.
    check("scoreboard_empty", NW'(sb.size()), NW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
